// File: rtl/qspi_rx_ctrl_if.sv
// Host/pad-side signal bundle of the quad-SPI read sequencer.
// The master side drives the transfer request; the slave side (the sequencer) drives the bus controls.
interface qspi_rx_ctrl_if;
  logic        start_i;
  logic        abort_i;
  logic [7:0]  cmd_i;
  logic [23:0] addr_i;
  logic [3:0]  dummy_i;
  logic [7:0]  nwords_i;
  logic        lsb_first_i;
  logic        busy_o;
  logic        done_o;
  logic        sclk_o;
  logic        cs_no;
  logic [3:0]  qsd_o;
  logic        qsd_oe_o;
  logic        rx_valid_o;
  logic        rx_lsb_o;
  logic        rx_msb_o;
  logic        word_valid_o;
  logic [7:0]  word_cnt_o;
  logic [2:0]  state_dbg;

  // start_i is a level request sampled only while idle; there is no ready signal,
  // busy_o high means any start_i is ignored until the cycle after done_o.
  modport master (
    output start_i, abort_i, cmd_i, addr_i, dummy_i, nwords_i, lsb_first_i,
    input  busy_o, done_o, sclk_o, cs_no, qsd_o, qsd_oe_o, rx_valid_o,
           rx_lsb_o, rx_msb_o, word_valid_o, word_cnt_o, state_dbg
  );
  modport slave (
    input  start_i, abort_i, cmd_i, addr_i, dummy_i, nwords_i, lsb_first_i,
    output busy_o, done_o, sclk_o, cs_no, qsd_o, qsd_oe_o, rx_valid_o,
           rx_lsb_o, rx_msb_o, word_valid_o, word_cnt_o, state_dbg
  );
endinterface

// File: rtl/qspi_rx_ctrl.sv
// Quad-SPI read sequencer: command, address, dummy and data phases with SCLK/CS_n generation
// and per-nibble control of the downstream RX shift register.
module qspi_rx_ctrl #(
  parameter int CLK_DIV = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  qspi_rx_ctrl_if.slave bus
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_FINISH, S_DONE
  } state_t;

  state_t      r_state;
  logic [DW-1:0] r_div_cnt;
  logic [2:0]  r_idx;
  logic [3:0]  r_dcnt;
  logic [10:0] r_rise_cnt;
  logic [2:0]  r_nib;
  logic [7:0]  r_cmd;
  logic [23:0] r_addr;
  logic [3:0]  r_dummy;
  logic [7:0]  r_nwords;
  logic        r_lsb_first;
  logic        r_busy, r_done, r_sclk, r_cs_n, r_oe;
  logic [3:0]  r_qsd;
  logic        r_rx_valid, r_rx_lsb, r_rx_msb, r_word_valid;
  logic [7:0]  r_word_cnt;

  logic       w_term, w_rise, w_fall;
  logic [3:0] w_addr_nib;

  assign w_term = (r_div_cnt == DIV_TC);
  assign w_rise = !r_cs_n && w_term && !r_sclk;
  assign w_fall = !r_cs_n && w_term && r_sclk;

  // Address nibble that follows the one currently on the lanes.
  always_comb begin
    w_addr_nib = r_addr[3:0];
    case (r_idx)
      3'd0:    w_addr_nib = r_addr[19:16];
      3'd1:    w_addr_nib = r_addr[15:12];
      3'd2:    w_addr_nib = r_addr[11:8];
      3'd3:    w_addr_nib = r_addr[7:4];
      default: w_addr_nib = r_addr[3:0];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_div_cnt    <= '0;
      r_idx        <= '0;
      r_dcnt       <= '0;
      r_rise_cnt   <= '0;
      r_nib        <= '0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_dummy      <= '0;
      r_nwords     <= '0;
      r_lsb_first  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_oe         <= 1'b0;
      r_qsd        <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_lsb     <= 1'b0;
      r_rx_msb     <= 1'b0;
      r_word_valid <= 1'b0;
      r_word_cnt   <= '0;
    end else if (bus.abort_i) begin
      r_state      <= S_IDLE;
      r_div_cnt    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_oe         <= 1'b0;
      r_qsd        <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_lsb     <= 1'b0;
      r_rx_msb     <= 1'b0;
      r_word_valid <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_word_valid <= 1'b0;

      // Word completion trails the 8th nibble strobe by one cycle, even past the DATA exit.
      if (r_rx_valid) begin
        r_nib <= r_nib + 3'd1;
        if (r_nib == 3'd7) begin
          r_word_valid <= 1'b1;
          r_word_cnt   <= r_word_cnt + 8'd1;
        end
      end

      if (!r_cs_n) begin
        if (w_term) begin
          r_div_cnt <= '0;
          r_sclk    <= !r_sclk;
        end else begin
          r_div_cnt <= r_div_cnt + DW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_state     <= S_CMD;
            r_cmd       <= bus.cmd_i;
            r_addr      <= bus.addr_i;
            r_dummy     <= bus.dummy_i;
            r_nwords    <= bus.nwords_i;
            r_lsb_first <= bus.lsb_first_i;
            r_cs_n      <= 1'b0;
            r_busy      <= 1'b1;
            r_oe        <= 1'b1;
            r_qsd       <= bus.cmd_i[7:4];
            r_word_cnt  <= '0;
            r_div_cnt   <= '0;
            r_sclk      <= 1'b0;
            r_idx       <= '0;
          end
        end
        S_CMD: begin
          if (w_fall) begin
            if (r_idx == 3'd1) begin
              r_state <= S_ADDR;
              r_idx   <= '0;
              r_qsd   <= r_addr[23:20];
            end else begin
              r_idx <= r_idx + 3'd1;
              r_qsd <= r_cmd[3:0];
            end
          end
        end
        S_ADDR: begin
          if (w_fall) begin
            if (r_idx == 3'd5) begin
              r_oe  <= 1'b0;
              r_qsd <= '0;
              if (r_dummy != 4'd0) begin
                r_state <= S_DUMMY;
                r_dcnt  <= '0;
              end else if (r_nwords != 8'd0) begin
                r_state    <= S_DATA;
                r_rise_cnt <= '0;
                r_nib      <= '0;
                r_rx_lsb   <= r_lsb_first;
                r_rx_msb   <= !r_lsb_first;
              end else begin
                r_state <= S_FINISH;
                r_cs_n  <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
              r_qsd <= w_addr_nib;
            end
          end
        end
        S_DUMMY: begin
          if (w_rise) r_dcnt <= r_dcnt + 4'd1;
          if (w_fall && (r_dcnt == r_dummy)) begin
            if (r_nwords != 8'd0) begin
              r_state    <= S_DATA;
              r_rise_cnt <= '0;
              r_nib      <= '0;
              r_rx_lsb   <= r_lsb_first;
              r_rx_msb   <= !r_lsb_first;
            end else begin
              r_state <= S_FINISH;
              r_cs_n  <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_rise) begin
            r_rx_valid <= 1'b1;
            r_rise_cnt <= r_rise_cnt + 11'd1;
          end
          if (w_fall && (r_rise_cnt == {r_nwords, 3'b000})) begin
            r_state  <= S_FINISH;
            r_cs_n   <= 1'b1;
            r_rx_lsb <= 1'b0;
            r_rx_msb <= 1'b0;
          end
        end
        S_FINISH: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.sclk_o       = r_sclk;
  assign bus.cs_no        = r_cs_n;
  assign bus.qsd_o        = r_qsd;
  assign bus.qsd_oe_o     = r_oe;
  assign bus.rx_valid_o   = r_rx_valid;
  assign bus.rx_lsb_o     = r_rx_lsb;
  assign bus.rx_msb_o     = r_rx_msb;
  assign bus.word_valid_o = r_word_valid;
  assign bus.word_cnt_o   = r_word_cnt;
  assign bus.state_dbg    = r_state;
endmodule

// File: tb/tb_qspi_rx_ctrl.sv
// Bench for qspi_rx_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) checked against an
// event-level model of a read transfer (nibble order, rise counts, strobes, words, done).
module tb_qspi_rx_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qspi_rx_ctrl_if b0 ();
  qspi_rx_ctrl_if b1 ();

  qspi_rx_ctrl #(.CLK_DIV(2)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(b0.slave));
  qspi_rx_ctrl #(.CLK_DIV(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));

  logic cur = 1'b0;
  logic       m_busy, m_done, m_sclk, m_cs_n, m_oe, m_rxv, m_lsb, m_msb, m_wv;
  logic [3:0] m_qsd;
  logic [7:0] m_wcnt;
  assign m_busy = cur ? b1.busy_o       : b0.busy_o;
  assign m_done = cur ? b1.done_o       : b0.done_o;
  assign m_sclk = cur ? b1.sclk_o       : b0.sclk_o;
  assign m_cs_n = cur ? b1.cs_no        : b0.cs_no;
  assign m_oe   = cur ? b1.qsd_oe_o     : b0.qsd_oe_o;
  assign m_rxv  = cur ? b1.rx_valid_o   : b0.rx_valid_o;
  assign m_lsb  = cur ? b1.rx_lsb_o     : b0.rx_lsb_o;
  assign m_msb  = cur ? b1.rx_msb_o     : b0.rx_msb_o;
  assign m_wv   = cur ? b1.word_valid_o : b0.word_valid_o;
  assign m_qsd  = cur ? b1.qsd_o        : b0.qsd_o;
  assign m_wcnt = cur ? b1.word_cnt_o   : b0.word_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic s, input logic v);
    if (s) b1.start_i = v; else b0.start_i = v;
  endtask

  task automatic set_abort(input logic s, input logic v);
    if (s) b1.abort_i = v; else b0.abort_i = v;
  endtask

  task automatic set_params(input logic [7:0] cmd, input logic [23:0] addr,
                            input logic [3:0] dummy, input logic [7:0] nw, input logic lsb);
    b0.cmd_i = cmd;   b1.cmd_i = cmd;
    b0.addr_i = addr; b1.addr_i = addr;
    b0.dummy_i = dummy; b1.dummy_i = dummy;
    b0.nwords_i = nw; b1.nwords_i = nw;
    b0.lsb_first_i = lsb; b1.lsb_first_i = lsb;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".busy"}, m_busy, 0);
    check({tag, ".done"}, m_done, 0);
    check({tag, ".sclk"}, m_sclk, 0);
    check({tag, ".cs_n"}, m_cs_n, 1);
    check({tag, ".qsd"}, m_qsd, 0);
    check({tag, ".oe"}, m_oe, 0);
    check({tag, ".rx_valid"}, m_rxv, 0);
    check({tag, ".rx_lsb"}, m_lsb, 0);
    check({tag, ".rx_msb"}, m_msb, 0);
    check({tag, ".word_valid"}, m_wv, 0);
    check({tag, ".word_cnt"}, m_wcnt, 0);
  endtask

  // One transfer on instance s, observed at negedges. abort_at >= 0 aborts right after
  // that many data strobes; hold keeps start_i high and swaps cmd_i to cmd2 mid-transfer.
  task automatic run_xfer(input logic s, input logic [7:0] cmd, input logic [23:0] addr,
                          input logic [3:0] dummy, input logic [7:0] nw, input logic lsb,
                          input int abort_at, input logic hold, input logic [7:0] cmd2);
    int div, n, rises, rxv, wv, dones, first_rise, last_rise;
    int bad_q, bad_sp, bad_rx, bad_wv, bad_busy;
    logic prev_sclk, wv_exp, fin, rise_now;
    logic [31:0] frame;
    logic [3:0] e;
    div = s ? 1 : 2;
    n = 0; rises = 0; rxv = 0; wv = 0; dones = 0; first_rise = -1; last_rise = 0;
    bad_q = 0; bad_sp = 0; bad_rx = 0; bad_wv = 0; bad_busy = 0;
    prev_sclk = 1'b0; wv_exp = 1'b0; fin = 1'b0;
    frame = {cmd, addr};
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(frame[31 - 4*k -: 4]);
    cur = s;
    @(negedge clk);
    set_params(cmd, addr, dummy, nw, lsb);
    set_start(s, 1'b1);
    while (!fin && n < 20000) begin
      @(negedge clk);
      if (n == 0) begin
        if (hold) begin b0.cmd_i = cmd2; b1.cmd_i = cmd2; end
        else set_start(s, 1'b0);
      end
      rise_now = m_sclk && !prev_sclk;
      if (rise_now) begin
        if (first_rise < 0) first_rise = n;
        else if (n - last_rise != 2*div) bad_sp++;
        last_rise = n;
        if (rises < 8) begin
          e = exp_q.pop_front();
          if (m_qsd !== e || m_oe !== 1'b1) bad_q++;
        end else if (m_qsd !== 4'h0 || m_oe !== 1'b0) bad_q++;
        if (m_cs_n !== 1'b0) bad_q++;
        rises++;
      end
      if (m_wv !== wv_exp) bad_wv++;
      if (m_wv === 1'b1) begin
        wv++;
        if (m_wcnt !== 8'(wv)) bad_wv++;
      end
      wv_exp = 1'b0;
      if (m_rxv === 1'b1) begin
        if (!rise_now || rises < 9 + int'(dummy)) bad_rx++;
        if (m_lsb !== lsb || m_msb !== !lsb) bad_rx++;
        rxv++;
        wv_exp = (rxv % 8 == 0);
      end
      if (m_done === 1'b1) begin dones++; fin = 1'b1; end
      else if (m_busy !== 1'b1) bad_busy++;
      if (abort_at >= 0 && m_rxv === 1'b1 && rxv == abort_at) begin
        set_abort(s, 1'b1);
        @(negedge clk);
        set_abort(s, 1'b0);
        check("abort.cs_n", m_cs_n, 1);
        check("abort.sclk", m_sclk, 0);
        check("abort.busy", m_busy, 0);
        check("abort.oe", m_oe, 0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (m_done === 1'b1) dones++;
        end
        check("abort.no_done", dones, 0);
        return;
      end
      prev_sclk = m_sclk;
      n++;
    end
    check("done_reached", fin, 1);
    check("first_rise", first_rise, div);
    check("sclk_rises", rises, 8 + int'(dummy) + 8*int'(nw));
    check("nibbles_oe", bad_q, 0);
    check("rise_spacing", bad_sp, 0);
    check("rx_valid_cnt", rxv, 8*int'(nw));
    check("rx_valid_bad", bad_rx, 0);
    check("word_valid_cnt", wv, nw);
    check("word_valid_bad", bad_wv, 0);
    check("word_cnt", m_wcnt, nw);
    check("busy_during", bad_busy, 0);
    check("end.busy", m_busy, 0);
    check("end.cs_n", m_cs_n, 1);
    check("end.sclk", m_sclk, 0);
    check("end.dir", {m_lsb, m_msb}, 0);
    if (hold) begin
      @(negedge clk);
      check("hold.idle_cs_n", m_cs_n, 1);
      @(negedge clk);
      check("hold.restart_cs_n", m_cs_n, 0);
      check("hold.restart_qsd", m_qsd, cmd2[7:4]);
      set_start(s, 1'b0);
      fin = 1'b0;
      for (int k = 0; k < 20000 && !fin; k++) begin
        @(negedge clk);
        if (m_done === 1'b1) fin = 1'b1;
      end
      check("hold.second_done", fin, 1);
    end
  endtask

  initial begin
    int rises;
    logic prev;
    rst = 1'b1;
    b0.start_i = 1'b0; b1.start_i = 1'b0;
    b0.abort_i = 1'b0; b1.abort_i = 1'b0;
    set_params(8'h00, 24'h0, 4'h0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    cur = 1'b0; check_reset_vals("reset0");
    cur = 1'b1; check_reset_vals("reset1");
    rst = 1'b0;
    @(negedge clk);

    run_xfer(1'b0, 8'hEB, 24'h123456, 4'd4, 8'd1, 1'b0, -1, 1'b0, 8'h00);
    run_xfer(1'b0, 8'h6B, 24'hABCDEF, 4'd0, 8'd0, 1'b0, -1, 1'b0, 8'h00);
    run_xfer(1'b1, 8'hEB, 24'h000100, 4'd2, 8'd3, 1'b1, -1, 1'b0, 8'h00);
    run_xfer(1'b0, 8'hEB, 24'h5A5A5A, 4'd1, 8'd2, 1'b0, 3, 1'b0, 8'h00);
    run_xfer(1'b0, 8'hEB, 24'hC0FFEE, 4'd3, 8'd1, 1'b1, -1, 1'b0, 8'h00);

    // Reset pulsed while the address nibbles are on the lanes.
    cur = 1'b0;
    @(negedge clk);
    set_params(8'hEB, 24'h987654, 4'd2, 8'd2, 1'b0);
    set_start(1'b0, 1'b1);
    @(negedge clk);
    set_start(1'b0, 1'b0);
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 200 && rises < 4; k++) begin
      if (m_sclk && !prev) rises++;
      prev = m_sclk;
      if (rises < 4) @(negedge clk);
    end
    check("mid_addr_reached", rises, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("mid_addr_rst");

    run_xfer(1'b0, 8'hEB, 24'h010203, 4'd0, 8'd1, 1'b1, -1, 1'b1, 8'h3B);

    for (int t = 0; t < 6; t++) begin
      run_xfer(1'(t % 2), 8'($urandom_range(0, 255)), 24'($urandom),
               4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), -1, 1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
